// File: rtl/key_note_engine.sv
// key_note_engine: synchronised, debounced priority key scanner that drives registered
// note rate words with note_on/note_off strobes and a programmable release hold.
// Define OCTAVE_EN to add the oct_up/oct_dn ports and a -1..+2 octave shift on note load.
module key_note_engine #(
    parameter int NKEYS           = 4,
    parameter int RATE_W          = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RELEASE_CYCLES  = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NKEYS-1:0]  keys_n,
`ifdef OCTAVE_EN
    input  logic              oct_up,
    input  logic              oct_dn,
`endif
    output logic [RATE_W-1:0] sample_rate,
    output logic [RATE_W-1:0] arm_rate,
    output logic [2:0]        note_idx,
    output logic              note_on,
    output logic              note_off,
    output logic              active
);
    typedef enum logic [1:0] {IDLE, NOTE, RELEASE} state_t;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [11:0] SR_TAB [8] = '{12'd1046, 12'd1174, 12'd1318, 12'd1396,
                                           12'd1568, 12'd1760, 12'd1976, 12'd2093};
    localparam logic [11:0] ARM_TAB [8] = '{12'd300, 12'd250, 12'd200, 12'd100,
                                            12'd90, 12'd80, 12'd70, 12'd60};

    logic [NKEYS-1:0]  s1_q, s2_q, cand_q, cand_d, stab_q, stab_d, sync;
    logic [DW-1:0]     db_cnt_q, db_cnt_d;
    state_t            state_q, state_d;
    logic [RW-1:0]     rel_cnt_q, rel_cnt_d;
    logic [RATE_W-1:0] sr_q, sr_d, arm_q, arm_d, sr_load, arm_load;
    logic [2:0]        idx_q, idx_d, win;
    logic              on_q, on_d, off_q, off_d, active_q, active_d, load;
    logic [31:0]       sr_raw, arm_raw;
`ifdef OCTAVE_EN
    // Octave is encoded 0,1,2 for 0..+2 and 3 for -1, so +1/-1 wrap naturally across -1<->0.
    logic [1:0]        oct_q, oct_d;
`endif

    function automatic logic [2:0] lowest(input logic [NKEYS-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = NKEYS - 1; i >= 0; i--)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    // Restart the stability count on any change of the synced vector; accept it once it has held long enough.
    always_comb begin
        sync     = ~s2_q;
        cand_d   = sync;
        db_cnt_d = (sync != cand_q) ? '0 :
                   (db_cnt_q == DW'(DEBOUNCE_CYCLES)) ? db_cnt_q : db_cnt_q + DW'(1);
        stab_d   = (sync == cand_q && db_cnt_q == DW'(DEBOUNCE_CYCLES)) ? cand_q : stab_q;
    end

`ifdef OCTAVE_EN
    // Clamp the octave at -1 and +2; simultaneous pulses cancel.
    always_comb begin
        oct_d = oct_q;
        if (oct_up && !oct_dn && oct_q != 2'd2) oct_d = oct_q + 2'd1;
        if (oct_dn && !oct_up && oct_q != 2'd3) oct_d = oct_q - 2'd1;
    end
`endif

    // Rate words for the winner of the vector being accepted this edge, saturated to RATE_W.
    always_comb begin
        win = lowest(stab_d);
`ifdef OCTAVE_EN
        sr_raw = (oct_q == 2'd3) ? 32'(SR_TAB[win]) >> 1 : 32'(SR_TAB[win]) << oct_q;
`else
        sr_raw = 32'(SR_TAB[win]);
`endif
        arm_raw  = 32'(ARM_TAB[win]);
        sr_load  = (|(sr_raw >> RATE_W)) ? '1 : RATE_W'(sr_raw);
        arm_load = (|(arm_raw >> RATE_W)) ? '1 : RATE_W'(arm_raw);
    end

    // Note FSM: load on a new winner, hold through release, then fall silent.
    always_comb begin
        state_d   = state_q;
        rel_cnt_d = rel_cnt_q;
        sr_d      = sr_q;
        arm_d     = arm_q;
        idx_d     = idx_q;
        on_d      = 1'b0;
        off_d     = 1'b0;
        load      = 1'b0;
        if (state_q == IDLE) begin
            load = stab_d != '0;
        end else if (state_q == NOTE) begin
            load = stab_d != '0 && win != idx_q;
            if (stab_d == '0) begin
                state_d   = RELEASE;
                off_d     = 1'b1;
                rel_cnt_d = '0;
            end
        end else begin
            load = stab_d != '0;
            if (!load && rel_cnt_q == RW'(RELEASE_CYCLES - 1)) begin
                state_d = IDLE;
                sr_d    = '0;
                arm_d   = '0;
                idx_d   = '0;
            end else begin
                rel_cnt_d = rel_cnt_q + RW'(1);
            end
        end
        if (load) begin
            state_d = NOTE;
            sr_d    = sr_load;
            arm_d   = arm_load;
            idx_d   = win;
            on_d    = 1'b1;
        end
        active_d = state_d != IDLE;
    end

    // State registers; reset silences everything at once without a note_off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= '1;
            s2_q      <= '1;
            cand_q    <= '0;
            stab_q    <= '0;
            db_cnt_q  <= '0;
            state_q   <= IDLE;
            rel_cnt_q <= '0;
            sr_q      <= '0;
            arm_q     <= '0;
            idx_q     <= '0;
            on_q      <= 1'b0;
            off_q     <= 1'b0;
            active_q  <= 1'b0;
`ifdef OCTAVE_EN
            oct_q     <= '0;
`endif
        end else begin
            s1_q      <= keys_n;
            s2_q      <= s1_q;
            cand_q    <= cand_d;
            stab_q    <= stab_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            rel_cnt_q <= rel_cnt_d;
            sr_q      <= sr_d;
            arm_q     <= arm_d;
            idx_q     <= idx_d;
            on_q      <= on_d;
            off_q     <= off_d;
            active_q  <= active_d;
`ifdef OCTAVE_EN
            oct_q     <= oct_d;
`endif
        end
    end

    assign sample_rate = sr_q;
    assign arm_rate    = arm_q;
    assign note_idx    = idx_q;
    assign note_on     = on_q;
    assign note_off    = off_q;
    assign active      = active_q;
endmodule

// File: tb/tb_key_note_engine.sv
// tb_key_note_engine: scoreboard bench; stimulus queues expected note events, a monitor pops and compares them.
module tb_key_note_engine;
    localparam int ON = 0, OFF = 1, IDL = 2;

    typedef struct {
        int kind;
        int sr;
        int arm;
        int idx;
        int cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  keys_n = 4'hF;
`ifdef OCTAVE_EN
    logic        oct_up = 1'b0;
    logic        oct_dn = 1'b0;
`endif
    logic [15:0] sample_rate, arm_rate;
    logic [2:0]  note_idx;
    logic        note_on, note_off, active;

    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    bit   act_prev = 1'b0;
    ev_t  q[$];

    key_note_engine #(
        .NKEYS(4), .RATE_W(16), .DEBOUNCE_CYCLES(4), .RELEASE_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .keys_n(keys_n),
`ifdef OCTAVE_EN
        .oct_up(oct_up),
        .oct_dn(oct_dn),
`endif
        .sample_rate(sample_rate),
        .arm_rate(arm_rate),
        .note_idx(note_idx),
        .note_on(note_on),
        .note_off(note_off),
        .active(active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_silent(input string name);
        check(name, int'({sample_rate, arm_rate, note_idx, note_on, note_off, active}), 0);
    endtask

    task automatic expect_ev(input int k, input int sr, input int arm, input int idx, input int dly);
        q.push_back('{k, sr, arm, idx, cyc + dly});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any note_on, note_off or drop of active is an event that must match the queue head.
    always @(negedge clk) begin
        int  k;
        ev_t e;
        if (reset) begin
            act_prev = 1'b0;
        end else begin
            if (note_on || note_off || (act_prev && !active)) begin
                k = (note_on && note_off) ? 3 : note_on ? ON : note_off ? OFF : IDL;
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL event: unexpected kind=%0d sr=%0d arm=%0d idx=%0d cyc=%0d",
                             k, sample_rate, arm_rate, note_idx, cyc);
                end else begin
                    e = q.pop_front();
                    if (k == e.kind && int'(sample_rate) == e.sr && int'(arm_rate) == e.arm &&
                        int'(note_idx) == e.idx && cyc == e.cyc)
                        passed++;
                    else
                        $display("FAIL event: got kind=%0d sr=%0d arm=%0d idx=%0d cyc=%0d, want kind=%0d sr=%0d arm=%0d idx=%0d cyc=%0d",
                                 k, sample_rate, arm_rate, note_idx, cyc,
                                 e.kind, e.sr, e.arm, e.idx, e.cyc);
                end
            end
            act_prev = active;
        end
    end

    initial begin
        #1 check_silent("reset_async");
        step(3);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_silent("idle_after_reset");
        end
        keys_n = 4'b1110;
        expect_ev(ON, 1046, 300, 0, 8);
        step(12);
        keys_n = 4'b1010;
        step(12);
        keys_n = 4'b1011;
        expect_ev(ON, 1318, 200, 2, 8);
        step(12);
        keys_n = 4'b1111;
        expect_ev(OFF, 1318, 200, 2, 8);
        expect_ev(IDL, 0, 0, 0, 16);
        step(12);
        check("release_hold_rate", int'(sample_rate), 1318);
        check("release_active", int'(active), 1);
        step(8);
        keys_n = 4'b0111;
        expect_ev(ON, 1396, 100, 3, 8);
        step(12);
        keys_n = 4'b1111;
        expect_ev(OFF, 1396, 100, 3, 8);
        step(7);
        keys_n = 4'b1101;
        expect_ev(ON, 1174, 250, 1, 8);
        step(12);
        keys_n = 4'b1111;
        expect_ev(OFF, 1174, 250, 1, 8);
        expect_ev(IDL, 0, 0, 0, 16);
        step(20);
        for (int i = 0; i < 20; i++) begin
            keys_n = keys_n ^ 4'b0001;
            step(2);
        end
        step(10);
        check("bounce_inactive", int'(active), 0);
        keys_n = 4'b1101;
        expect_ev(ON, 1174, 250, 1, 8);
        step(11);
        #2 reset = 1'b1;
        #1 check_silent("reset_mid_note");
        step(2);
        reset = 1'b0;
        expect_ev(ON, 1174, 250, 1, 8);
        step(12);
        keys_n = 4'b1111;
        expect_ev(OFF, 1174, 250, 1, 8);
        expect_ev(IDL, 0, 0, 0, 16);
        step(20);
`ifdef OCTAVE_EN
        for (int i = 0; i < 3; i++) begin
            oct_up = 1'b1;
            step(1);
            oct_up = 1'b0;
            step(1);
        end
        keys_n = 4'b1101;
        expect_ev(ON, 4696, 250, 1, 8);
        step(12);
        keys_n = 4'b1111;
        expect_ev(OFF, 4696, 250, 1, 8);
        expect_ev(IDL, 0, 0, 0, 16);
        step(20);
        for (int i = 0; i < 4; i++) begin
            oct_dn = 1'b1;
            step(1);
            oct_dn = 1'b0;
            step(1);
        end
        keys_n = 4'b1101;
        expect_ev(ON, 587, 250, 1, 8);
        step(12);
        keys_n = 4'b1111;
        expect_ev(OFF, 587, 250, 1, 8);
        expect_ev(IDL, 0, 0, 0, 16);
        step(20);
`endif
        check("events_outstanding", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
